// File: rtl/lane_scheduler.sv
// lane_scheduler: sequences the car slots of one road lane.
//   On Start it latches lane speed/direction/row, then enables each car slot in
//   ascending order, GAP_FRAMES frames apart, giving each a pseudo-random type.
//   Stop releases all slots at once.
// Ports:
//   FrameClk    frame-rate clock; all state changes on its rising edge
//   Reset       synchronous, active-high
//   Start/Stop  level start pulse / level end or abort
//   Level       current level, sets lane speed
//   LaneLeft    lane direction, 1 = cars travel left
//   LaneY       lane top row in pixels
//   Seed        LFSR seed (0 is replaced by 8'hA5)
//   SpawnEnable per-slot enable to the car instances
//   Type        per-slot car type, slot i in bits [2i+1:2i]
//   Speed, FaceLeft, SpawnX, SpawnY  shared lane parameters
//   Running     high while a level is in progress
module lane_scheduler #(
   parameter int unsigned CARS       = 3,
   parameter int unsigned GAP_FRAMES = 64,
   parameter int unsigned TYPES      = 4
) (
   input  logic              FrameClk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stop,
   input  logic [2:0]        Level,
   input  logic              LaneLeft,
   input  logic [9:0]        LaneY,
   input  logic [7:0]        Seed,
   output logic [CARS-1:0]   SpawnEnable,
   output logic [2*CARS-1:0] Type,
   output logic [2:0]        Speed,
   output logic              FaceLeft,
   output logic [9:0]        SpawnX,
   output logic [9:0]        SpawnY,
   output logic              Running
);

   localparam int unsigned SlotW    = $clog2(CARS + 1);
   localparam logic [1:0]  TypeMask = 2'(TYPES - 1);
   localparam logic [7:0]  LfsrInit = 8'hA5;
   // Off-screen entry columns around the 100..739 range for a 48 px car.
   localparam logic [9:0]  XLeft    = 10'd740;
   localparam logic [9:0]  XRight   = 10'd51;

   typedef enum logic [1:0] {StIdle, StLoad, StStagger, StRun} state_e;

   state_e             state_q, state_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [SlotW-1:0]   slot_q, slot_d;
   logic [7:0]         gap_q, gap_d;
   logic [CARS-1:0]    en_d;
   logic [2*CARS-1:0]  type_d;
   logic [2:0]         speed_d;
   logic               face_d;
   logic [9:0]         spawn_x_d, spawn_y_d;
   logic [7:0]         lfsr_step;

   // Galois LFSR, x^8+x^6+x^5+x^4+1, shifting right.
   assign lfsr_step = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

   assign Running = (state_q != StIdle);

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      slot_d    = slot_q;
      gap_d     = gap_q;
      en_d      = SpawnEnable;
      type_d    = Type;
      speed_d   = Speed;
      face_d    = FaceLeft;
      spawn_x_d = SpawnX;
      spawn_y_d = SpawnY;
      unique case (state_q)
         StIdle: begin
            if (Start && !Stop) state_d = StLoad;
         end
         StLoad: begin
            if (Stop) begin
               state_d = StIdle;
               en_d    = '0;
            end else begin
               speed_d   = (Level == 3'd7) ? 3'd7 : Level + 3'd1;
               face_d    = LaneLeft;
               spawn_y_d = LaneY;
               spawn_x_d = LaneLeft ? XLeft : XRight;
               lfsr_d    = (Seed == 8'h00) ? LfsrInit : Seed;
               slot_d    = '0;
               gap_d     = '0;
               state_d   = StStagger;
            end
         end
         StStagger: begin
            if (Stop) begin
               state_d = StIdle;
               en_d    = '0;
            end else if (slot_q == SlotW'(CARS)) begin
               state_d = StRun;
            end else if (gap_q == 8'd0) begin
               for (int i = 0; i < int'(CARS); i++) begin
                  if (slot_q == SlotW'(i)) begin
                     en_d[i]           = 1'b1;
                     type_d[2*i +: 2]  = lfsr_q[1:0] & TypeMask;
                  end
               end
               lfsr_d = lfsr_step;
               slot_d = slot_q + SlotW'(1);
               gap_d  = 8'(GAP_FRAMES - 1);
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         StRun: begin
            if (Stop) begin
               state_d = StIdle;
               en_d    = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge FrameClk) begin
      if (Reset) begin
         state_q     <= StIdle;
         lfsr_q      <= LfsrInit;
         slot_q      <= '0;
         gap_q       <= '0;
         SpawnEnable <= '0;
         Type        <= '0;
         Speed       <= '0;
         FaceLeft    <= 1'b0;
         SpawnX      <= '0;
         SpawnY      <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         slot_q      <= slot_d;
         gap_q       <= gap_d;
         SpawnEnable <= en_d;
         Type        <= type_d;
         Speed       <= speed_d;
         FaceLeft    <= face_d;
         SpawnX      <= spawn_x_d;
         SpawnY      <= spawn_y_d;
      end
   end

endmodule

// File: tb/tb_lane_scheduler.sv
// tb_lane_scheduler: directed bench for lane_scheduler (CARS=3, GAP_FRAMES=64).
// Frame E0 is the edge that samples Start; E1 is the LOAD edge; slot i rises
// at E(2 + 64*i). Outputs are sampled 1 ns after each rising edge.
module tb_lane_scheduler;

   logic       FrameClk = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic       Stop = 1'b0;
   logic [2:0] Level = 3'd0;
   logic       LaneLeft = 1'b0;
   logic [9:0] LaneY = 10'd0;
   logic [7:0] Seed = 8'h00;
   logic [2:0] SpawnEnable;
   logic [5:0] Type;
   logic [2:0] Speed;
   logic       FaceLeft;
   logic [9:0] SpawnX;
   logic [9:0] SpawnY;
   logic       Running;

   int tests = 0;
   int fails = 0;

   lane_scheduler #(.CARS(3), .GAP_FRAMES(64), .TYPES(4)) dut (
      .FrameClk    (FrameClk),
      .Reset       (Reset),
      .Start       (Start),
      .Stop        (Stop),
      .Level       (Level),
      .LaneLeft    (LaneLeft),
      .LaneY       (LaneY),
      .Seed        (Seed),
      .SpawnEnable (SpawnEnable),
      .Type        (Type),
      .Speed       (Speed),
      .FaceLeft    (FaceLeft),
      .SpawnX      (SpawnX),
      .SpawnY      (SpawnY),
      .Running     (Running)
   );

   always #5 FrameClk = ~FrameClk;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge FrameClk);
         #1;
      end
   endtask

   // Pulse Start (edge E0) and advance through the LOAD edge (E1).
   task automatic start_level();
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      tests++;
      if ({SpawnEnable, Type, Speed, FaceLeft, SpawnX, SpawnY, Running} !== '0) begin
         fails++;
         $display("FAIL reset_values: en=%b type=%h speed=%0d face=%b x=%0d y=%0d run=%b, all 0 required",
                  SpawnEnable, Type, Speed, FaceLeft, SpawnX, SpawnY, Running);
      end
   endtask

   // Seed 5B -> types 3,1,2 (LFSR 5B, 95, F2).
   task automatic test_first_start();
      Seed = 8'h5B; Level = 3'd2; LaneLeft = 1'b1; LaneY = 10'd200;
      Start = 1'b1;
      tick(1);
      Start = 1'b0;
      tests++;
      if (Running !== 1'b1 || Speed !== 3'd0) begin
         fails++;
         $display("FAIL load_state: run=%b speed=%0d, required run=1 speed=0", Running, Speed);
      end
      tick(1);
      tests++;
      if (Speed !== 3'd3 || FaceLeft !== 1'b1 || SpawnX !== 10'd740 || SpawnY !== 10'd200
          || SpawnEnable !== 3'b000) begin
         fails++;
         $display("FAIL load_latch: speed=%0d face=%b x=%0d y=%0d en=%b, required 3 1 740 200 000",
                  Speed, FaceLeft, SpawnX, SpawnY, SpawnEnable);
      end
      tick(1);
      tests++;
      if (SpawnEnable !== 3'b001 || Type !== 6'h03) begin
         fails++;
         $display("FAIL slot0_rise: en=%b type=%h, required 001 03", SpawnEnable, Type);
      end
      tick(63);
      tests++;
      if (SpawnEnable !== 3'b001) begin
         fails++;
         $display("FAIL slot1_early: en=%b, required 001", SpawnEnable);
      end
      tick(1);
      tests++;
      if (SpawnEnable !== 3'b011 || Type !== 6'h07) begin
         fails++;
         $display("FAIL slot1_rise: en=%b type=%h, required 011 07", SpawnEnable, Type);
      end
      tick(63);
      tests++;
      if (SpawnEnable !== 3'b011) begin
         fails++;
         $display("FAIL slot2_early: en=%b, required 011", SpawnEnable);
      end
      tick(1);
      tests++;
      if (SpawnEnable !== 3'b111 || Type !== 6'h27) begin
         fails++;
         $display("FAIL slot2_rise: en=%b type=%h, required 111 27", SpawnEnable, Type);
      end
   endtask

   task automatic test_run_hold();
      for (int f = 0; f < 12; f++) begin
         Start    = f[0];
         Level    = 3'(f);
         LaneY    = 10'(f * 37);
         LaneLeft = ~LaneLeft;
         Seed     = 8'(f * 13);
         tick(1);
         tests++;
         if (SpawnEnable !== 3'b111 || Type !== 6'h27 || Speed !== 3'd3 || FaceLeft !== 1'b1
             || SpawnX !== 10'd740 || SpawnY !== 10'd200 || Running !== 1'b1) begin
            fails++;
            $display("FAIL run_hold[%0d]: en=%b type=%h speed=%0d face=%b x=%0d y=%0d run=%b",
                     f, SpawnEnable, Type, Speed, FaceLeft, SpawnX, SpawnY, Running);
         end
      end
      Start = 1'b0;
      Stop  = 1'b1;
      tick(1);
      Stop = 1'b0;
      tests++;
      if (SpawnEnable !== 3'b000 || Running !== 1'b0 || Type !== 6'h27 || Speed !== 3'd3
          || SpawnX !== 10'd740 || SpawnY !== 10'd200 || FaceLeft !== 1'b1) begin
         fails++;
         $display("FAIL run_stop: en=%b run=%b type=%h speed=%0d x=%0d y=%0d face=%b",
                  SpawnEnable, Running, Type, Speed, SpawnX, SpawnY, FaceLeft);
      end
   endtask

   // Seed 0 -> A5: types 1,2,1 (LFSR A5, EA, 75).
   task automatic test_seed0_saturate();
      Seed = 8'h00; Level = 3'd7; LaneLeft = 1'b0; LaneY = 10'd333;
      start_level();
      tests++;
      if (Speed !== 3'd7 || FaceLeft !== 1'b0 || SpawnX !== 10'd51 || SpawnY !== 10'd333) begin
         fails++;
         $display("FAIL sat_latch: speed=%0d face=%b x=%0d y=%0d, required 7 0 51 333",
                  Speed, FaceLeft, SpawnX, SpawnY);
      end
      tick(129);
      tests++;
      if (SpawnEnable !== 3'b111 || Type !== 6'h19) begin
         fails++;
         $display("FAIL seed0_types: en=%b type=%h, required 111 19", SpawnEnable, Type);
      end
      Stop = 1'b1;
      tick(1);
      Stop = 1'b0;
   endtask

   task automatic test_stop_stagger();
      Seed = 8'h5B; Level = 3'd2; LaneLeft = 1'b1; LaneY = 10'd200;
      start_level();
      tick(69);
      tests++;
      if (SpawnEnable !== 3'b011 || Type !== 6'h17) begin
         fails++;
         $display("FAIL pre_stop: en=%b type=%h, required 011 17", SpawnEnable, Type);
      end
      Stop = 1'b1;
      tick(1);
      Stop = 1'b0;
      tests++;
      if (SpawnEnable !== 3'b000 || Running !== 1'b0 || Type !== 6'h17) begin
         fails++;
         $display("FAIL stagger_stop: en=%b run=%b type=%h, required 000 0 17",
                  SpawnEnable, Running, Type);
      end
      tick(2);
      tests++;
      if (SpawnEnable !== 3'b000 || Running !== 1'b0) begin
         fails++;
         $display("FAIL stays_idle: en=%b run=%b, required 000 0", SpawnEnable, Running);
      end
      // Restart with seed 0 must start at slot 0 with a freshly loaded LFSR.
      Seed = 8'h00;
      start_level();
      tick(1);
      tests++;
      if (SpawnEnable !== 3'b001 || Type !== 6'h15) begin
         fails++;
         $display("FAIL restart_slot0: en=%b type=%h, required 001 15", SpawnEnable, Type);
      end
      tick(64);
      tests++;
      if (SpawnEnable !== 3'b011 || Type !== 6'h19) begin
         fails++;
         $display("FAIL restart_slot1: en=%b type=%h, required 011 19", SpawnEnable, Type);
      end
      Stop = 1'b1;
      tick(1);
      Stop = 1'b0;
   endtask

   task automatic test_start_stop_idle();
      Start = 1'b1;
      Stop  = 1'b1;
      tick(1);
      Start = 1'b0;
      Stop  = 1'b0;
      tick(3);
      tests++;
      if (SpawnEnable !== 3'b000 || Running !== 1'b0) begin
         fails++;
         $display("FAIL start_stop_idle: en=%b run=%b, required 000 0", SpawnEnable, Running);
      end
   endtask

   task automatic test_reset_mid();
      Seed = 8'h5B; Level = 3'd2; LaneLeft = 1'b1; LaneY = 10'd200;
      start_level();
      tick(65);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      tests++;
      if ({SpawnEnable, Type, Speed, FaceLeft, SpawnX, SpawnY, Running} !== '0) begin
         fails++;
         $display("FAIL reset_mid: en=%b type=%h speed=%0d face=%b x=%0d y=%0d run=%b",
                  SpawnEnable, Type, Speed, FaceLeft, SpawnX, SpawnY, Running);
      end
      start_level();
      tests++;
      if (Speed !== 3'd3 || SpawnX !== 10'd740 || SpawnEnable !== 3'b000) begin
         fails++;
         $display("FAIL rerun_load: speed=%0d x=%0d en=%b, required 3 740 000",
                  Speed, SpawnX, SpawnEnable);
      end
      tick(1);
      tests++;
      if (SpawnEnable !== 3'b001 || Type !== 6'h03) begin
         fails++;
         $display("FAIL rerun_slot0: en=%b type=%h, required 001 03", SpawnEnable, Type);
      end
      tick(63);
      tests++;
      if (SpawnEnable !== 3'b001) begin
         fails++;
         $display("FAIL rerun_slot1_early: en=%b, required 001", SpawnEnable);
      end
      tick(1);
      tests++;
      if (SpawnEnable !== 3'b011) begin
         fails++;
         $display("FAIL rerun_slot1: en=%b, required 011", SpawnEnable);
      end
      tick(64);
      tests++;
      if (SpawnEnable !== 3'b111 || Type !== 6'h27) begin
         fails++;
         $display("FAIL rerun_slot2: en=%b type=%h, required 111 27", SpawnEnable, Type);
      end
   endtask

   initial begin
      tick(1);
      test_reset();
      test_first_start();
      test_run_hold();
      test_seed0_saturate();
      test_stop_stagger();
      test_start_stop_idle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lane_scheduler.md
Name: lane_scheduler

Overview:
Per-lane controller that sequences a bank of CARS car instances for one road lane. On level start it latches lane speed and direction, then staggers spawn of each car slot in time so cars enter with even spacing. Car types are picked pseudo-randomly, and all slots are released on stop. Sits between the game-state FSM (Start/Stop/Level) and the car instances of one lane.

Parameters:
CARS, 3, number of car slots driven by this lane (1..8)
GAP_FRAMES, 64, frames between successive slot spawns (1..255)
TYPES, 4, number of car types; Type = LFSR value mod TYPES (power of two, max 4)

Ports:
FrameClk  input  1  frame-rate clock, all state changes on posedge
Reset  input  1  synchronous, active-high
Start  input  1  level start pulse, sampled on FrameClk
Stop  input  1  level end or abort, sampled on FrameClk
Level  input  3  current level 0..7
LaneLeft  input  1  lane direction, 1 = cars travel left
LaneY  input  10  lane top row in screen pixels
Seed  input  8  LFSR seed, 0 is replaced by 8'hA5
SpawnEnable  output  CARS  per-slot enable to car instance
Type  output  2*CARS  per-slot car type, slot i in bits [2i+1:2i]
Speed  output  3  shared lane speed, px/frame
FaceLeft  output  1  shared direction
SpawnX  output  10  shared spawn column
SpawnY  output  10  shared spawn row
Running  output  1  high in LOAD, STAGGER, RUN

Behaviour:
- States are IDLE, LOAD, STAGGER and RUN.
- Reset, on the same edge: state IDLE; SpawnEnable=0; Type=0; Speed=0; FaceLeft=0; SpawnX=0; SpawnY=0; Running=0; LFSR=8'hA5; slot index=0; gap counter=0.
- IDLE:
  - Start=1 and Stop=0 -> LOAD.
  - Start=1 and Stop=1 -> stay IDLE (Stop wins).
- LOAD (exactly 1 frame):
  - Latch Speed = min(Level+1, 7).
  - Latch FaceLeft = LaneLeft and SpawnY = LaneY.
  - Latch SpawnX = 740 if LaneLeft, else 51. These are the off-screen entry points of the car movement range 100..739 with car width 48.
  - Load LFSR = Seed, or 8'hA5 if Seed=0.
  - Clear slot index and gap counter.
  - Next state STAGGER.
- STAGGER:
  - Gap counter=0: set Type[slot] = LFSR[1:0] & (TYPES-1) and SpawnEnable[slot]=1 on the same edge. Step the LFSR (Galois, taps x^8+x^6+x^5+x^4+1). Increment slot. Set gap counter = GAP_FRAMES-1.
  - Otherwise decrement gap counter.
  - The frame after the last slot is enabled -> RUN.
  - Slot i enable rises exactly 1 + i*GAP_FRAMES frames after the LOAD edge.
- RUN: hold all outputs constant; only Stop is acted on.
- Stop in LOAD, STAGGER or RUN:
  - Next edge -> IDLE, SpawnEnable=0, Running=0.
  - Type, Speed, FaceLeft, SpawnX and SpawnY keep their last values.
- Start while not IDLE is ignored. A restart requires Stop, then Start.
- Invariants:
  - Type[i], Speed, FaceLeft, SpawnX and SpawnY never change while SpawnEnable[i]=1. Car instances read them continuously.
  - Type[i] is written only on the edge that raises SpawnEnable[i].
  - SpawnEnable bits only rise one at a time in ascending slot order. They fall together.
- Level and LaneY changes outside LOAD have no effect until the next LOAD.
- Spacing note, not checked by hardware: leading-edge spacing = Speed*GAP_FRAMES px. The default gives >=64 px, which exceeds car width 48.
- Reset asserted in any state overrides Start and Stop and gives the reset values on that edge.

Test Plan:
- Reset, then Start, Level=2, LaneLeft=1, LaneY=200, CARS=3, GAP_FRAMES=64 -> LOAD edge latches Speed=3, FaceLeft=1, SpawnX=740, SpawnY=200. Enables rise at +1, +65, +129 frames. RUN from +130.
- Seed=0, LaneLeft=0, Level=7 -> SpawnX=51, Speed=7 (saturated). Type[0..2] match LFSR from 8'hA5 stepped 0, 1, 2 times, low 2 bits.
- Stop at +70 during STAGGER -> next edge SpawnEnable=000, Running=0, state IDLE. A new Start restarts from slot 0 with a reloaded LFSR.
- Start and Stop high together in IDLE -> remains IDLE, all enables 0. Start pulses during RUN -> no output change.
- Toggle Level, LaneY and LaneLeft every frame during RUN -> Speed, SpawnY, FaceLeft and Type stay constant until Stop.
- Reset asserted at +66 -> same edge all outputs 0, LFSR=8'hA5. A Start on the following frame gives the same timing as the first scenario.
